// File: rtl/uart_axil_pkg.sv
// uart_axil_pkg: register map, AXI response codes and FSM state encodings for uart_axil_regs
package uart_axil_pkg;
    localparam logic [3:0] REG_CTRL    = 4'h0;
    localparam logic [3:0] REG_BAUD    = 4'h4;
    localparam logic [3:0] REG_TXDATA  = 4'h8;
    localparam logic [3:0] REG_SCRATCH = 4'hC;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [0:0] W_IDLE      = 1'b0;
    localparam logic [0:0] W_RESP      = 1'b1;
    localparam logic [0:0] R_IDLE      = 1'b0;
    localparam logic [0:0] R_DATA      = 1'b1;
endpackage

// File: rtl/uart_axil_wstrb_merge.sv
// uart_axil_wstrb_merge: per-byte merge of new write data over the old register value
module uart_axil_wstrb_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] o_data
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign o_data[8*b +: 8] = i_wstrb[b] ? i_wdata[8*b +: 8] : i_old[8*b +: 8];
    end
endmodule

// File: rtl/uart_axil_regs.sv
// uart_axil_regs: AXI4-Lite slave with four 32-bit UART registers; UART_AXIL_ALIGN_CHECK_EN makes misaligned accesses return SLVERR
module uart_axil_regs
    import uart_axil_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 4,
    parameter logic [31:0] BAUD_DIV_RST = 32'd868
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [31:0]           ctrl_o,
    output logic [31:0]           baud_div_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_wr_o
);
    logic [31:0]           r_regs [4];
    logic [0:0]            r_wstate, r_rstate;
    logic                  r_aw_done, r_w_done, r_awready, r_wready, r_bvalid, r_tx_wr;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [31:0]           r_wdata, r_rdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_bresp, r_rresp;
    logic                  r_arready, r_rvalid;

    logic                  w_aw_hs, w_w_hs, w_aw_have, w_w_have, w_commit, w_b_hs;
    logic                  w_aw_done_nx, w_w_done_nx, w_werr, w_rerr, w_ar_hs, w_r_hs;
    logic [0:0]            w_wstate_nx;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [31:0]           w_wdata, w_old, w_merged;
    logic [3:0]            w_wstrb;
    logic                  w_unused;

    assign w_aw_hs   = s_axi_awvalid && r_awready;
    assign w_w_hs    = s_axi_wvalid && r_wready;
    assign w_aw_have = r_aw_done || w_aw_hs;
    assign w_w_have  = r_w_done || w_w_hs;
    // Whichever channel arrives second supplies its fields straight from the bus
    assign w_waddr   = r_aw_done ? r_awaddr : s_axi_awaddr;
    assign w_wdata   = r_w_done ? r_wdata : s_axi_wdata;
    assign w_wstrb   = r_w_done ? r_wstrb : s_axi_wstrb;
    assign w_commit  = (r_wstate == W_IDLE) && w_aw_have && w_w_have;
    assign w_b_hs    = r_bvalid && s_axi_bready;

    assign w_wstate_nx  = w_commit ? W_RESP : (w_b_hs ? W_IDLE : r_wstate);
    assign w_aw_done_nx = !w_commit && w_aw_have;
    assign w_w_done_nx  = !w_commit && w_w_have;

    assign w_ar_hs = s_axi_arvalid && r_arready;
    assign w_r_hs  = r_rvalid && s_axi_rready;

`ifdef UART_AXIL_ALIGN_CHECK_EN
    assign w_werr = |w_waddr[1:0];
    assign w_rerr = |s_axi_araddr[1:0];
`else
    assign w_werr = 1'b0;
    assign w_rerr = 1'b0;
`endif

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, w_waddr, s_axi_araddr};
    assign w_old    = r_regs[w_waddr[3:2]];

    uart_axil_wstrb_merge u_merge (
        .i_old   (w_old),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .o_data  (w_merged)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wstate  <= W_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_tx_wr   <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nx;
            r_aw_done <= w_aw_done_nx;
            r_w_done  <= w_w_done_nx;
            r_awready <= (w_wstate_nx == W_IDLE) && !w_aw_done_nx;
            r_wready  <= (w_wstate_nx == W_IDLE) && !w_w_done_nx;
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            r_bvalid <= w_commit || (r_bvalid && !s_axi_bready);
            if (w_commit) r_bresp <= w_werr ? RESP_SLVERR : RESP_OKAY;
            r_tx_wr <= w_commit && !w_werr && w_wstrb[0] && (w_waddr[3:2] == REG_TXDATA[3:2]);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_regs[REG_CTRL[3:2]]    <= '0;
            r_regs[REG_BAUD[3:2]]    <= BAUD_DIV_RST;
            r_regs[REG_TXDATA[3:2]]  <= '0;
            r_regs[REG_SCRATCH[3:2]] <= '0;
        end else if (w_commit && !w_werr) begin
            r_regs[w_waddr[3:2]] <= w_merged;
        end
    end

    // Read sampling uses pre-edge register contents, so a same-edge write is not seen
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_arready <= !w_ar_hs && (w_r_hs || r_rstate == R_IDLE);
            if (w_ar_hs) begin
                r_rstate <= R_DATA;
                r_rvalid <= 1'b1;
                r_rdata  <= w_rerr ? 32'd0 : r_regs[s_axi_araddr[3:2]];
                r_rresp  <= w_rerr ? RESP_SLVERR : RESP_OKAY;
            end else if (w_r_hs) begin
                r_rstate <= R_IDLE;
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign ctrl_o        = r_regs[REG_CTRL[3:2]];
    assign baud_div_o    = r_regs[REG_BAUD[3:2]];
    assign tx_data_o     = r_regs[REG_TXDATA[3:2]][7:0];
    assign tx_wr_o       = r_tx_wr;
endmodule

// File: tb/tb_uart_axil_regs.sv
// tb_uart_axil_regs: directed self-checking bench for uart_axil_regs
module tb_uart_axil_regs;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [3:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] ctrl_o, baud_div_o;
    logic [7:0]  tx_data_o;
    logic        tx_wr_o;

    int vecs = 0;
    int errs = 0;
    int tx_pulses = 0;

    always #5 ACLK = ~ACLK;

    uart_axil_regs #(.ADDR_WIDTH(4), .BAUD_DIV_RST(32'd868)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ctrl_o(ctrl_o), .baud_div_o(baud_div_o), .tx_data_o(tx_data_o), .tx_wr_o(tx_wr_o)
    );

    always @(negedge ACLK) if (ARESETN && tx_wr_o) tx_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        logic af, wf;
        logic done;
        s_axi_awaddr = a;
        s_axi_wdata = d;
        s_axi_wstrb = s;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        resp = 2'b11;
        for (int i = 0; i < 20 && (s_axi_awvalid || s_axi_wvalid); i++) begin
            af = s_axi_awready;
            wf = s_axi_wready;
            @(posedge ACLK); #1;
            if (af) s_axi_awvalid = 1'b0;
            if (wf) s_axi_wvalid = 1'b0;
        end
        chk("wr_accept_pending", 32'(s_axi_awvalid || s_axi_wvalid), 32'd0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_axi_bvalid) begin
                resp = s_axi_bresp;
                done = 1'b1;
            end
            @(posedge ACLK); #1;
        end
        s_axi_bready = 1'b0;
        chk("wr_bvalid_seen", 32'(done), 32'd1);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        logic done;
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        s_axi_rready = 1'b1;
        d = '1;
        resp = 2'b11;
        for (int i = 0; i < 20 && s_axi_arvalid; i++) begin
            done = s_axi_arready;
            @(posedge ACLK); #1;
            if (done) s_axi_arvalid = 1'b0;
        end
        chk("rd_ar_pending", 32'(s_axi_arvalid), 32'd0);
        s_axi_arvalid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_axi_rvalid) begin
                d = s_axi_rdata;
                resp = s_axi_rresp;
                done = 1'b1;
            end
            @(posedge ACLK); #1;
        end
        s_axi_rready = 1'b0;
        chk("rd_rvalid_seen", 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_vals [4];
        exp_vals[0] = 32'h1; exp_vals[1] = 32'h2; exp_vals[2] = 32'h3; exp_vals[3] = 32'h4;

        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_ctrl", ctrl_o, 32'd0);
        chk("rst_baud", baud_div_o, 32'd868);
        chk("rst_tx_wr", 32'(tx_wr_o), 32'd0);
        @(negedge ACLK) ARESETN = 1'b1;
        @(posedge ACLK); #1;

        rd(4'h4, d, r);
        chk("rd_baud_rst", d, 32'h364);
        chk("rd_baud_rst_resp", 32'(r), 32'd0);

        for (int i = 0; i < 4; i++) begin
            wr(4'(i * 4), exp_vals[i], 4'hF, r);
            chk("wr_seq_bresp", 32'(r), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            rd(4'(i * 4), d, r);
            chk("rd_seq_data", d, exp_vals[i]);
            chk("rd_seq_rresp", 32'(r), 32'd0);
        end
        chk("tx_pulse_count1", 32'(tx_pulses), 32'd1);
        chk("tx_data", 32'(tx_data_o), 32'h03);
        chk("ctrl_out", ctrl_o, 32'h1);
        chk("baud_out", baud_div_o, 32'h2);

        wr(4'hC, 32'hAABBCCDD, 4'hF, r);
        wr(4'hC, 32'h11223344, 4'b0101, r);
        rd(4'hC, d, r);
        chk("strb_merge", d, 32'hAA22CC44);

        s_axi_wdata = 32'h55;
        s_axi_wstrb = 4'hF;
        s_axi_wvalid = 1'b1;
        @(posedge ACLK); #1;
        s_axi_wvalid = 1'b0;
        chk("wfirst_wready_low", 32'(s_axi_wready), 32'd0);
        chk("wfirst_awready_high", 32'(s_axi_awready), 32'd1);
        repeat (2) @(posedge ACLK);
        #1;
        chk("wfirst_no_bvalid", 32'(s_axi_bvalid), 32'd0);
        s_axi_awaddr = 4'h0;
        s_axi_awvalid = 1'b1;
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0;
        chk("wfirst_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("wfirst_ctrl", ctrl_o, 32'h55);
        for (int i = 0; i < 5; i++) begin
            @(posedge ACLK); #1;
            chk("bhold_bvalid", 32'(s_axi_bvalid), 32'd1);
            chk("bhold_ready", 32'({s_axi_awready, s_axi_wready}), 32'd0);
        end
        s_axi_bready = 1'b1;
        @(posedge ACLK); #1;
        s_axi_bready = 1'b0;
        chk("bhs_bvalid_low", 32'(s_axi_bvalid), 32'd0);
        chk("bhs_ready_back", 32'({s_axi_awready, s_axi_wready}), 32'd3);

        s_axi_awaddr = 4'h8;
        s_axi_wdata = 32'h9;
        s_axi_wstrb = 4'hF;
        s_axi_araddr = 4'h8;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        s_axi_arvalid = 1'b1;
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        s_axi_arvalid = 1'b0;
        chk("same_edge_rvalid", 32'(s_axi_rvalid), 32'd1);
        chk("same_edge_old", s_axi_rdata, 32'h3);
        chk("same_edge_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("same_edge_tx_wr", 32'(tx_wr_o), 32'd1);
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        @(posedge ACLK); #1;
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        chk("tx_wr_one_cycle", 32'(tx_wr_o), 32'd0);
        rd(4'h8, d, r);
        chk("same_edge_new", d, 32'h9);
        chk("tx_pulse_count2", 32'(tx_pulses), 32'd2);

`ifdef UART_AXIL_ALIGN_CHECK_EN
        wr(4'h6, 32'hDEAD, 4'hF, r);
        chk("align_wr_slverr", 32'(r), 32'd2);
        chk("align_baud_kept", baud_div_o, 32'h2);
        rd(4'h5, d, r);
        chk("align_rd_slverr", 32'(r), 32'd2);
        chk("align_rd_zero", d, 32'd0);
`else
        wr(4'h6, 32'hDEAD, 4'hF, r);
        chk("noalign_wr_okay", 32'(r), 32'd0);
        chk("noalign_baud", baud_div_o, 32'hDEAD);
        rd(4'h5, d, r);
        chk("noalign_rd_okay", 32'(r), 32'd0);
        chk("noalign_rd_data", d, 32'hDEAD);
`endif
        chk("tx_pulse_count3", 32'(tx_pulses), 32'd2);

        s_axi_awaddr = 4'h4;
        s_axi_wdata = 32'h1234;
        s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid = 1'b1;
        @(posedge ACLK); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid = 1'b0;
        chk("pre_rst_bvalid", 32'(s_axi_bvalid), 32'd1);
        chk("pre_rst_baud", baud_div_o, 32'h1234);
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("mid_rst_baud", baud_div_o, 32'd868);
        chk("mid_rst_ctrl", ctrl_o, 32'd0);
        chk("mid_rst_txdata", 32'(tx_data_o), 32'd0);
        chk("mid_rst_awready", 32'(s_axi_awready), 32'd0);
        @(negedge ACLK) ARESETN = 1'b1;
        @(posedge ACLK); #1;
        rd(4'hC, d, r);
        chk("post_rst_scratch", d, 32'd0);
        rd(4'h4, d, r);
        chk("post_rst_baud", d, 32'd868);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/uart_axil_regs.md
Name: uart_axil_regs

Overview:
- AXI4-Lite slave register block fronting the UART core: four 32-bit read/write registers at offsets 0x0, 0x4, 0x8 and 0xC.
- Sits between the AXI VIP master (or PS interconnect) and the UART TX/RX logic; exports register contents and a TX-write strobe to the core.
- Any written value reads back unchanged, so sequential write-then-read-compare sweeps over all four offsets pass.

Parameters:
- ADDR_WIDTH, 4, AXI address bits; only [3:2] decoded.
- BAUD_DIV_RST, 32'd868, reset value of REG1 (115200 baud at 100 MHz).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
- ctrl_o  out  32  REG0 (CTRL).
- baud_div_o  out  32  REG1 (BAUD_DIV).
- tx_data_o  out  8  REG2[7:0] (TX_DATA).
- tx_wr_o  out  1  one-cycle pulse on a REG2 write with wstrb[0]=1.
- (REG3 is SCRATCH: internal only, no output.)

Behaviour:
- Reset (async assert, sync release):
  - REG0, REG2, REG3 = 0; REG1 = BAUD_DIV_RST.
  - All *ready, bvalid, rvalid and tx_wr_o = 0; bresp = rresp = 2'b00; rdata = 0.
- Write FSM states:
  - W_IDLE:
    - awready=1 until AW latched; wready=1 until W latched.
    - AW and W accepted independently, in either order or in the same cycle.
    - On the edge completing the second handshake: register updated per byte enables (byte k written iff wstrb[k]); bvalid set; go to W_RESP.
  - W_RESP:
    - awready=wready=0; bvalid held until bready.
    - On the B handshake edge: latches cleared, return to W_IDLE.
  - Latency: bvalid is visible 1 cycle after the final AW/W handshake. At most one write outstanding.
- tx_wr_o: asserted the cycle after a REG2 commit with wstrb[0]=1; exactly 1 cycle wide.
- Read FSM states:
  - R_IDLE: arready=1.
    - On the AR handshake edge: rdata = register selected by araddr[3:2]; rresp=OKAY; rvalid=1; go to R_DATA.
  - R_DATA: arready=0; rdata/rvalid held stable until rready; on the handshake return to R_IDLE.
  - Latency: 1 cycle from AR handshake to rvalid.
- Simultaneous events:
  - If an AR handshake and a write commit hit the same register on the same edge, the read returns the pre-write value.
  - Read and write channels never stall each other.
- Reset mid-transaction: any in-flight response is dropped, all FSMs return to idle, no partial register update.
- Address bits above [3:2] are ignored (aliasing).

Optional Feature:
- Macro UART_AXIL_ALIGN_CHECK_EN.
- Defined: a transaction with addr[1:0] != 0 returns SLVERR (2'b10).
  - Writes: no register update, no tx_wr_o.
  - Reads: rdata = 0.
- Undefined: addr[1:0] ignored, always OKAY.

Decomposition:
- Shared package uart_axil_pkg holds:
  - register offsets (REG_CTRL=0x0, REG_BAUD=0x4, REG_TXDATA=0x8, REG_SCRATCH=0xC);
  - RESP_OKAY / RESP_SLVERR constants;
  - the write- and read-FSM state enums.
- One natural sub-module, uart_axil_wstrb_merge: combinational byte-enable merge of old value, wdata and wstrb. Everything else is flat.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read all four back -> data 1, 2, 3, 4, all BRESP/RRESP=OKAY; tx_wr_o pulses once, on the 0x8 write; tx_data_o=0x03.
- Read 0x4 straight after reset -> 868 (0x364).
- Write 0xAABBCCDD then 0x11223344 with wstrb=4'b0101 to 0xC -> readback 0xAA22CC44.
- W (0x55) presented 3 cycles before AW to 0x0; bready held low 5 cycles:
  - -> bvalid held stable throughout;
  - no new AW/W accepted until the B handshake;
  - ctrl_o=0x55.
- Same-edge read and write of 0x8 (old 0x3, new 0x9) -> read returns 0x3; a later read returns 0x9.
- ARESETN asserted while bvalid=1 -> bvalid drops immediately; registers return to reset values.
- With UART_AXIL_ALIGN_CHECK_EN: write to 0x6 -> SLVERR and REG1 unchanged.
